// File: rtl/phase_freq_est_pkg.sv
// Shared definitions for the phase/frequency estimation stage: FSM states
// and angle scaling constants (degrees with ANG_FRAC fractional bits).
package phase_freq_est_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_DIFF,
    ST_ACCUM
  } state_t;

  localparam int ANG_FRAC = 10;
  localparam int DEG180   = 180 << ANG_FRAC;
  localparam int DEG360   = 2 * DEG180;

endpackage

// File: rtl/phase_wrap.sv
// Wrapped angle difference: (cur - prev) computed one bit wider, then folded
// by one full turn so the result lands in [-180deg, +180deg).
module phase_wrap
  import phase_freq_est_pkg::*;
#(
  parameter int OUTSIZE = 19,
  parameter int WRAP180 = DEG180,
  parameter int WRAP360 = DEG360
) (
  input  logic signed [OUTSIZE-1:0] i_cur,
  input  logic signed [OUTSIZE-1:0] i_prev,
  output logic signed [OUTSIZE-1:0] o_delta
);

  localparam logic signed [OUTSIZE:0] P180 = (OUTSIZE+1)'(WRAP180);
  localparam logic signed [OUTSIZE:0] N180 = (OUTSIZE+1)'(-WRAP180);
  localparam logic signed [OUTSIZE:0] F360 = (OUTSIZE+1)'(WRAP360);

  logic signed [OUTSIZE:0] w_diff;

  // Widened difference followed by a single +/-360 fold; +180 maps to -180.
  always_comb begin
    w_diff  = $signed({i_cur[OUTSIZE-1], i_cur}) - $signed({i_prev[OUTSIZE-1], i_prev});
    o_delta = w_diff[OUTSIZE-1:0];
    if (w_diff >= P180) begin
      o_delta = OUTSIZE'(w_diff - F360);
    end else if (w_diff < N180) begin
      o_delta = OUTSIZE'(w_diff + F360);
    end
  end

endmodule

// File: rtl/phase_freq_est.sv
// Sequences one phase conversion per I/Q sample, turns consecutive angles
// into a wrapped per-sample phase delta and averages 2^AVGLOG2 deltas into
// a frequency estimate.
module phase_freq_est
  import phase_freq_est_pkg::*;
#(
  parameter int INSIZE  = 13,
  parameter int OUTSIZE = 19,
  parameter int AVGLOG2 = 2,
  parameter int DEG180  = phase_freq_est_pkg::DEG180
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [INSIZE-1:0]  x_in,
  input  logic signed [INSIZE-1:0]  y_in,
  output logic                      pc_start,
  input  logic                      pc_busy,
  output logic signed [INSIZE-1:0]  pc_x,
  output logic signed [INSIZE-1:0]  pc_y,
  input  logic signed [OUTSIZE-1:0] pc_angle,
  output logic signed [OUTSIZE-1:0] delta_out,
  output logic                      delta_valid,
  output logic signed [OUTSIZE-1:0] freq_out,
  output logic                      freq_valid,
  output logic                      overrun
);

  localparam int ACCW = OUTSIZE + AVGLOG2;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_prev_valid;
  logic signed [OUTSIZE-1:0] r_cur;
  logic signed [OUTSIZE-1:0] r_prev;
  logic signed [ACCW-1:0]    r_acc;
  logic [AVGLOG2-1:0]        r_count;
  logic signed [OUTSIZE-1:0] w_delta;
  logic signed [ACCW-1:0]    w_acc_sum;

  // Window average: arithmetic shift, so negative sums round toward -inf.
  function automatic logic signed [OUTSIZE-1:0] avg_floor(input logic signed [ACCW-1:0] sum);
    return OUTSIZE'(sum >>> AVGLOG2);
  endfunction

  phase_wrap #(
    .OUTSIZE(OUTSIZE),
    .WRAP180(DEG180),
    .WRAP360(2 * DEG180)
  ) u_wrap (
    .i_cur  (r_cur),
    .i_prev (r_prev),
    .o_delta(w_delta)
  );

  assign w_acc_sum = r_acc + ACCW'(delta_out);

  // State register; async reset abandons any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    pc_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_START;
      end
      ST_START: begin
        pc_start = 1'b1;
        w_next   = ST_ARM;
      end
      ST_ARM:   w_next = ST_WAIT;
      ST_WAIT:  if (!pc_busy) w_next = ST_DIFF;
      ST_DIFF:  w_next = r_prev_valid ? ST_ACCUM : ST_IDLE;
      ST_ACCUM: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Sample capture, delta/average outputs, window counter and sticky overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_x         <= '0;
      pc_y         <= '0;
      delta_out    <= '0;
      delta_valid  <= 1'b0;
      freq_out     <= '0;
      freq_valid   <= 1'b0;
      overrun      <= 1'b0;
      r_prev_valid <= 1'b0;
      r_acc        <= '0;
      r_count      <= '0;
    end else begin
      delta_valid <= 1'b0;
      freq_valid  <= 1'b0;
      if (in_valid && !in_ready) overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            pc_x <= x_in;
            pc_y <= y_in;
          end
        end
        ST_DIFF: begin
          if (r_prev_valid) begin
            delta_out   <= w_delta;
            delta_valid <= 1'b1;
          end else begin
            r_prev_valid <= 1'b1;
          end
        end
        ST_ACCUM: begin
          r_count <= r_count + AVGLOG2'(1);
          if (r_count == '1) begin
            freq_out   <= avg_floor(w_acc_sum);
            freq_valid <= 1'b1;
            r_acc      <= '0;
          end else begin
            r_acc <= w_acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  // Angle history; only meaningful once r_prev_valid is set, so no reset.
  always_ff @(posedge clock) begin
    if (r_state == ST_WAIT && !pc_busy) r_cur <= pc_angle;
    if (r_state == ST_DIFF) r_prev <= r_cur;
  end

endmodule

// File: tb/tb_phase_freq_est.sv
module tb_phase_freq_est;

  localparam int INSIZE  = 13;
  localparam int OUTSIZE = 19;
  localparam int AVGLOG2 = 2;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic signed [INSIZE-1:0]  x_in = '0;
  logic signed [INSIZE-1:0]  y_in = '0;
  logic                      pc_start;
  logic                      pc_busy = 1'b0;
  logic signed [INSIZE-1:0]  pc_x;
  logic signed [INSIZE-1:0]  pc_y;
  logic signed [OUTSIZE-1:0] pc_angle = '0;
  logic signed [OUTSIZE-1:0] delta_out;
  logic                      delta_valid;
  logic signed [OUTSIZE-1:0] freq_out;
  logic                      freq_valid;
  logic                      overrun;

  int n_vec = 0;
  int n_bad = 0;
  int busy_len = 0;
  int bcnt = 0;
  int exp_delta[$];
  int exp_freq[$];

  phase_freq_est #(
    .INSIZE (INSIZE),
    .OUTSIZE(OUTSIZE),
    .AVGLOG2(AVGLOG2),
    .DEG180 (184320)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .y_in       (y_in),
    .pc_start   (pc_start),
    .pc_busy    (pc_busy),
    .pc_x       (pc_x),
    .pc_y       (pc_y),
    .pc_angle   (pc_angle),
    .delta_out  (delta_out),
    .delta_valid(delta_valid),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Phase calculator model: busy for busy_len cycles starting after pc_start.
  always @(posedge clock) begin
    if (pc_start && busy_len > 0) begin
      pc_busy <= 1'b1;
      bcnt    <= busy_len;
    end else if (bcnt > 0) begin
      if (bcnt == 1) pc_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_vec++;
    n_bad++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  // Scoreboard: every delta/freq pulse is matched against the queued value.
  always @(negedge clock) begin
    if (!reset) begin
      if (delta_valid) begin
        if (exp_delta.size() == 0) fail_now("delta_unexpected");
        else chk("delta_out", delta_out, exp_delta.pop_front());
      end
      if (freq_valid) begin
        if (exp_freq.size() == 0) fail_now("freq_unexpected");
        else chk("freq_out", freq_out, exp_freq.pop_front());
      end
    end
  end

  task automatic send(input int x, input int y, input int ang, input int blen);
    int t;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) fail_now("send_ready");
    pc_angle = OUTSIZE'(ang);
    busy_len = blen;
    x_in     = INSIZE'(x);
    y_in     = INSIZE'(y);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) fail_now("wait_idle");
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int lat;
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pc_start", pc_start, 0);
    chk("rst_delta_valid", delta_valid, 0);
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_delta_out", delta_out, 0);
    chk("rst_freq_out", freq_out, 0);
    chk("rst_pc_x", pc_x, 0);
    chk("rst_pc_y", pc_y, 0);
    reset = 1'b0;

    // 10deg then 30deg, slow calculator; first sample yields no delta
    exp_freq.push_back(40960);
    send(1, 2, 10240, 5);
    chk("pc_x_first", pc_x, 1);
    chk("pc_y_first", pc_y, 2);
    chk("ready_low_accept", in_ready, 0);
    wait_idle();
    exp_delta.push_back(20480);
    send(3, 4, 30720, 5);
    lat = 0;
    while (!delta_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!delta_valid) fail_now("delta_wait");
    chk("ready_low_accum", in_ready, 0);
    @(negedge clock);
    chk("ready_back", in_ready, 1);
    chk("delta_one_cycle", delta_valid, 0);

    // Instant calculator: accept to delta_valid is 4 cycles
    exp_delta.push_back(143360);
    send(5, 6, 174080, 0);
    lat = 1;
    while (!delta_valid && lat < 50) begin
      @(posedge clock);
      #1;
      if (!delta_valid) lat++;
    end
    chk("latency", lat, 4);
    wait_idle();

    // Wrap cases: 170->-170, -170->170, 170->0, 0->180
    exp_delta.push_back(20480);
    send(7, 8, -174080, 1);
    exp_delta.push_back(-20480);
    send(9, 10, 174080, 2);
    exp_delta.push_back(-174080);
    send(11, 12, 0, 0);
    exp_delta.push_back(-184320);
    send(13, 14, 184320, 3);
    wait_idle();

    // Reset while waiting on the calculator
    send(15, 16, 30000, 20);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_pc_start", pc_start, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (25) @(negedge clock);
    reset = 1'b0;
    exp_freq.push_back(23040);
    send(17, 18, 51200, 2);
    exp_delta.push_back(10240);
    send(19, 20, 61440, 1);
    exp_delta.push_back(10240);
    send(21, 22, 71680, 0);
    exp_delta.push_back(30720);
    send(23, 24, 102400, 4);
    exp_delta.push_back(40960);
    send(25, 26, 143360, 0);
    wait_idle();

    // Fresh window: 0,10,30,60,100 then -1,-1,-1,-2 units
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_freq.push_back(25600);
    exp_freq.push_back(-2);
    send(27, 28, 0, 0);
    exp_delta.push_back(10240);
    send(29, 30, 10240, 1);
    exp_delta.push_back(20480);
    send(31, 32, 30720, 0);
    exp_delta.push_back(30720);
    send(33, 34, 61440, 2);
    exp_delta.push_back(40960);
    send(35, 36, 102400, 0);
    exp_delta.push_back(-1);
    send(37, 38, 102399, 0);
    exp_delta.push_back(-1);
    send(39, 40, 102398, 1);
    exp_delta.push_back(-1);
    send(41, 42, 102397, 0);
    exp_delta.push_back(-2);
    send(43, 44, 102395, 0);
    wait_idle();

    // Sample offered while busy is dropped and flags overrun
    chk("overrun_clear", overrun, 0);
    exp_delta.push_back(10240);
    send(100, 9, 112635, 10);
    repeat (4) @(negedge clock);
    x_in = INSIZE'(777);
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    chk("drop_pc_x_busy", pc_x, 100);
    wait_idle();
    chk("drop_pc_x_idle", pc_x, 100);
    exp_delta.push_back(20480);
    send(200, 11, 133115, 0);
    chk("next_pc_x", pc_x, 200);
    wait_idle();
    chk("overrun_sticky", overrun, 1);

    repeat (3) @(negedge clock);
    chk("delta_queue_left", exp_delta.size(), 0);
    chk("freq_queue_left", exp_freq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_freq_est.md
Name: phase_freq_est

Overview:
- Downstream stage of the phase calculator in the Hilbert-filter chain.
- Accepts I/Q sample pairs and sequences one phase conversion per sample through the phase calculator's start/busy handshake.
- Captures each returned angle and computes the wrapped phase difference to the previous sample (instantaneous frequency, degrees/sample).
- Averages 2^AVGLOG2 differences into one frequency estimate.

Parameters:
- INSIZE, 13: width of the signed x/y sample.
- OUTSIZE, 19: width of the signed angle (degrees, 10 fractional bits, range ±180·1024).
- AVGLOG2, 2: log2 of the number of deltas averaged per estimate.
- DEG180, 184320: 180° in angle units (180·1024).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  new x_in/y_in sample offered.
- in_ready  out  1  high when in IDLE; a sample is accepted when in_valid && in_ready.
- x_in  in  INSIZE  signed I sample.
- y_in  in  INSIZE  signed Q sample.
- pc_start  out  1  start pulse to the phase calculator.
- pc_busy  in  1  busy from the phase calculator.
- pc_x  out  INSIZE  registered x to the phase calculator; held stable from accept until the next accept.
- pc_y  out  INSIZE  registered y, same rule as pc_x.
- pc_angle  in  OUTSIZE  signed angle returned by the phase calculator.
- delta_out  out  OUTSIZE  wrapped phase delta of the last sample.
- delta_valid  out  1  one-cycle pulse when delta_out updates.
- freq_out  out  OUTSIZE  averaged delta.
- freq_valid  out  1  one-cycle pulse when freq_out updates.
- overrun  out  1  sticky; set when in_valid is high while in_ready is low.

Behaviour:
- Reset (async, active-high):
  - Outputs: all 0, except in_ready=1.
  - Internal: state=IDLE, prev_valid=0, accumulator=0, count=0.
- FSM:
  - IDLE: on in_valid, register x_in/y_in into pc_x/pc_y -> START.
  - START: pc_start=1 for exactly this cycle -> ARM.
  - ARM: one guard cycle so busy can rise -> WAIT.
  - WAIT: stay while pc_busy=1. On pc_busy=0, capture pc_angle into cur -> DIFF.
  - DIFF:
    - If prev_valid=0: set prev=cur and prev_valid=1, no delta_valid pulse -> IDLE.
    - Otherwise compute d = cur - prev at OUTSIZE+1 bits, wrapped:
      - if d >= DEG180, d -= 2·DEG180;
      - if d < -DEG180, d += 2·DEG180.
    - The result lies in [-DEG180, DEG180) and fits OUTSIZE bits.
    - Register delta_out=d, pulse delta_valid, set prev=cur -> ACCUM.
  - ACCUM:
    - acc += sign-extended d (acc width OUTSIZE+AVGLOG2); count++.
    - When count wraps to 0: freq_out = acc >>> AVGLOG2 (arithmetic, truncation toward -inf), pulse freq_valid, clear acc in the same cycle.
    - -> IDLE.
- Latency: accept to delta_valid = 4 + phase-calculator busy cycles. freq_valid comes one cycle after the delta_valid that completes the window.
- in_valid outside IDLE: the sample is dropped and overrun is set. overrun clears only on reset.
- Simultaneous in_valid and returning to IDLE: the sample is accepted on the next cycle only if in_valid is still high. There is no skid buffer.
- Exactly ±180° difference wraps to -DEG180.
- Reset mid-operation: the FSM abandons the conversion, pc_start deasserts immediately, and the next sample is treated as the first (no delta).
- pc_busy already 0 in ARM/WAIT (instant calculator): legal; the angle is captured in the first WAIT cycle.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE, START, ARM, WAIT, DIFF, ACCUM);
  - angle constants DEG180 and DEG360;
  - the angle fractional-bit count (10).
- One natural sub-module: phase_wrap. It is a combinational (OUTSIZE+1)-bit difference plus ±360° fold, reusable by later unwrapping stages.
- The FSM, accumulator and counter stay in the top module.

Test Plan:
- Angles 10°, 30° (10240, 30720), calculator busy 5 cycles -> first sample gives no delta_valid; second gives delta_out=20480 and delta_valid one cycle; in_ready is low from accept through the ACCUM cycle.
- Wrap positive: angles 170°, -170° -> delta_out=+20480. Wrap negative: -170°, 170° -> delta_out=-20480. Exactly 0° then 180° -> delta_out=-184320.
- AVGLOG2=2, angles 0,10,30,60,100° -> deltas 10,20,30,40° -> single freq_valid with freq_out=25600; acc is cleared for the next window.
- Negative average: deltas -1,-1,-1,-2 units -> freq_out=-2 (arithmetic shift, floor).
- in_valid pulsed during WAIT -> overrun=1 and stays 1; that sample is never sent to pc_x; the following IDLE sample is processed normally.
- Assert reset during WAIT, release, send angles 50° then 60° -> no delta for 50°, delta_out=10240 for 60°; freq count restarts from 0.
